// File: rtl/card_layer_pkg.sv
// Shared types and constants for the card overlay layer.
package card_layer_pkg;

    localparam int unsigned NULL_CARD = 0;

    typedef enum logic [0:0] {IDLE, CLEAR} state_t;

    localparam int unsigned DEF_PAL_N = 8;
    localparam logic [11:0] DEFAULT_PAL [DEF_PAL_N] = '{
        12'h000, 12'h001, 12'hd23, 12'hff1, 12'h09d, 12'hfca, 12'haaa, 12'hfff
    };

    function automatic int unsigned map_aw(int unsigned grid_wb, int unsigned grid_hb);
        return grid_wb + grid_hb;
    endfunction

    function automatic int unsigned rom_aw(int unsigned card_b, int unsigned tile_hb,
                                           int unsigned tile_wb);
        return card_b + tile_hb + tile_wb;
    endfunction

endpackage

// File: rtl/card_rom.sv
// Card pixel ROM, address {card, row, col}; registered output.
// Contents: idx = card + row/8 + col/4 (mod 2^DATA_WIDTH), giving diagonal stripes.
module card_rom #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH = 3,
    parameter int unsigned TILE_WB    = 5,
    parameter int unsigned TILE_HB    = 6
) (
    input  logic                  clk_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0] data_d, data_q;

    always_comb begin
        data_d = DATA_WIDTH'(32'(addr_i >> (TILE_WB + TILE_HB))
                          + 32'(addr_i[TILE_WB +: TILE_HB] >> 3)
                          + 32'(addr_i[TILE_WB-1:0] >> 2));
    end

    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    assign data_o = data_q;

endmodule

// File: rtl/card_tile_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
module card_tile_ram #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Read-during-write returns the old contents.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/card_layer_src.sv
// Tile-based card overlay source: map RAM -> card ROM -> palette -> keyed RGB.
// Optional cursor border enabled by defining CARD_LAYER_CURSOR_EN.
module card_layer_src
    import card_layer_pkg::*;
#(
    parameter int unsigned   CD        = 12,
    parameter logic [CD-1:0] KEY_COLOR = '0,
    parameter int unsigned   TILE_WB   = 5,
    parameter int unsigned   TILE_HB   = 6,
    parameter int unsigned   GRID_WB   = 5,
    parameter int unsigned   GRID_HB   = 3,
    parameter int unsigned   CARD_B    = 4,
    parameter int unsigned   PIX_B     = 3
`ifdef CARD_LAYER_CURSOR_EN
    ,
    parameter logic [CD-1:0] CUR_COLOR = CD'(12'hff1)
`endif
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [10:0]        x,
    input  logic [10:0]        y,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [GRID_WB-1:0] wr_xt,
    input  logic [GRID_HB-1:0] wr_yt,
    input  logic [CARD_B-1:0]  wr_card,
    input  logic               clr_start,
    output logic               clr_busy,
    input  logic               pal_we,
    input  logic [PIX_B-1:0]   pal_idx,
    input  logic [CD-1:0]      pal_rgb,
`ifdef CARD_LAYER_CURSOR_EN
    input  logic [GRID_WB-1:0] cur_xt,
    input  logic [GRID_HB-1:0] cur_yt,
    input  logic               cur_on,
`endif
    output logic [CD-1:0]      osd_rgb
);

    localparam int unsigned MAP_AW = map_aw(GRID_WB, GRID_HB);
    localparam int unsigned ROM_AW = rom_aw(CARD_B, TILE_HB, TILE_WB);
    localparam int unsigned PAL_N  = 2**PIX_B;

    state_t              state_q, state_d;
    logic [MAP_AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic                rdy_q;
    logic                ram_we;
    logic [MAP_AW-1:0]   ram_waddr, ram_raddr;
    logic [CARD_B-1:0]   ram_wdata, card1;
    logic [CD-1:0]       pal_q [PAL_N];
    logic [CD-1:0]       pal_d [PAL_N];
    logic [TILE_HB-1:0]  row1_q, row1_d;
    logic [TILE_WB-1:0]  col1_q, col1_d;
    logic                inr1_q, inr1_d, inr2_q, inr2_d;
    logic [ROM_AW-1:0]   rom_addr;
    logic [PIX_B-1:0]    pix2;
    logic [CARD_B-1:0]   card2_q, card2_d;
    logic [CD-1:0]       osd_q, osd_d;
`ifdef CARD_LAYER_CURSOR_EN
    logic [TILE_HB-1:0]  row2_q, row2_d;
    logic [TILE_WB-1:0]  col2_q, col2_d;
    logic [GRID_WB-1:0]  txt1_q, txt1_d, txt2_q, txt2_d;
    logic [GRID_HB-1:0]  tyt1_q, tyt1_d, tyt2_q, tyt2_d;
    logic                cur_border;
`endif

    card_tile_ram #(
        .ADDR_WIDTH(MAP_AW),
        .DATA_WIDTH(CARD_B)
    ) u_map (
        .clk_i  (clk),
        .we_i   (ram_we),
        .waddr_i(ram_waddr),
        .wdata_i(ram_wdata),
        .raddr_i(ram_raddr),
        .rdata_o(card1)
    );

    card_rom #(
        .ADDR_WIDTH(ROM_AW),
        .DATA_WIDTH(PIX_B),
        .TILE_WB   (TILE_WB),
        .TILE_HB   (TILE_HB)
    ) u_rom (
        .clk_i (clk),
        .addr_i(rom_addr),
        .data_o(pix2)
    );

    // Host write / clear sequencer; rdy_q holds wr_ready low until the first clock after reset.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        wr_ready  = 1'b0;
        clr_busy  = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = {wr_yt, wr_xt};
        ram_wdata = wr_card;
        case (state_q)
            IDLE: begin
                wr_ready = rdy_q & ~clr_start;
                ram_we   = wr_valid & wr_ready;
                if (clr_start) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            CLEAR: begin
                clr_busy  = 1'b1;
                ram_we    = 1'b1;
                ram_waddr = clr_cnt_q;
                ram_wdata = CARD_B'(NULL_CARD);
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pal_d = pal_q;
        if (pal_we && pal_idx != '0) begin
            pal_d[pal_idx] = pal_rgb;
        end
    end

    always_comb begin
        ram_raddr = {y[TILE_HB +: GRID_HB], x[TILE_WB +: GRID_WB]};
        row1_d    = y[TILE_HB-1:0];
        col1_d    = x[TILE_WB-1:0];
        inr1_d    = ((x >> (TILE_WB + GRID_WB)) == '0) && ((y >> (TILE_HB + GRID_HB)) == '0);
        rom_addr  = {card1, row1_q, col1_q};
        card2_d   = card1;
        inr2_d    = inr1_q;
        osd_d     = pal_q[pix2];
        if (!inr2_q || card2_q == CARD_B'(NULL_CARD) || pix2 == '0) begin
            osd_d = KEY_COLOR;
        end
`ifdef CARD_LAYER_CURSOR_EN
        txt1_d     = x[TILE_WB +: GRID_WB];
        tyt1_d     = y[TILE_HB +: GRID_HB];
        txt2_d     = txt1_q;
        tyt2_d     = tyt1_q;
        row2_d     = row1_q;
        col2_d     = col1_q;
        cur_border = (row2_q == '0) || (row2_q == '1) || (col2_q == '0) || (col2_q == '1);
        if (cur_on && inr2_q && cur_border && txt2_q == cur_xt && tyt2_q == cur_yt &&
            (card2_q == CARD_B'(NULL_CARD) || pix2 != '0)) begin
            osd_d = CUR_COLOR;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
            rdy_q     <= 1'b0;
            row1_q    <= '0;
            col1_q    <= '0;
            inr1_q    <= 1'b0;
            inr2_q    <= 1'b0;
            card2_q   <= '0;
            osd_q     <= KEY_COLOR;
            for (int i = 0; i < PAL_N; i++) begin
                pal_q[i] <= (i < DEF_PAL_N) ? CD'(DEFAULT_PAL[i % DEF_PAL_N]) : '1;
            end
`ifdef CARD_LAYER_CURSOR_EN
            txt1_q <= '0;
            tyt1_q <= '0;
            txt2_q <= '0;
            tyt2_q <= '0;
            row2_q <= '0;
            col2_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rdy_q     <= 1'b1;
            row1_q    <= row1_d;
            col1_q    <= col1_d;
            inr1_q    <= inr1_d;
            inr2_q    <= inr2_d;
            card2_q   <= card2_d;
            osd_q     <= osd_d;
            pal_q     <= pal_d;
`ifdef CARD_LAYER_CURSOR_EN
            txt1_q <= txt1_d;
            tyt1_q <= tyt1_d;
            txt2_q <= txt2_d;
            tyt2_q <= tyt2_d;
            row2_q <= row2_d;
            col2_q <= col2_d;
`endif
        end
    end

    assign osd_rgb = osd_q;

endmodule

// File: tb/tb_card_layer_src.sv
// Directed + randomized bench for card_layer_src with a pixel-level reference model.
module tb_card_layer_src;

    localparam int KEY = 0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [10:0] x = '0, y = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [4:0]  wr_xt = '0;
    logic [2:0]  wr_yt = '0;
    logic [3:0]  wr_card = '0;
    logic        clr_start = 1'b0;
    logic        clr_busy;
    logic        pal_we = 1'b0;
    logic [2:0]  pal_idx = '0;
    logic [11:0] pal_rgb = '0;
    logic [11:0] osd_rgb;
`ifdef CARD_LAYER_CURSOR_EN
    logic [4:0]  cur_xt = '0;
    logic [2:0]  cur_yt = '0;
    logic        cur_on = 1'b0;
`endif

    always #5 clk = ~clk;

    card_layer_src dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .x        (x),
        .y        (y),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_xt    (wr_xt),
        .wr_yt    (wr_yt),
        .wr_card  (wr_card),
        .clr_start(clr_start),
        .clr_busy (clr_busy),
        .pal_we   (pal_we),
        .pal_idx  (pal_idx),
        .pal_rgb  (pal_rgb),
`ifdef CARD_LAYER_CURSOR_EN
        .cur_xt   (cur_xt),
        .cur_yt   (cur_yt),
        .cur_on   (cur_on),
`endif
        .osd_rgb  (osd_rgb)
    );

    int checks = 0;
    int errors = 0;
    int map_m [256];
    int pal_m [8];
    int def_pal [8] = '{'h000, 'h001, 'hd23, 'hff1, 'h09d, 'hfca, 'haaa, 'hfff};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: what a 1024x512 screen of 32x64 cards should show at (xx,yy).
    function automatic int expect_pix(int xx, int yy);
        int card, row, col, idx;
        if (xx >= 1024 || yy >= 512) return KEY;
        card = map_m[(yy / 64) * 32 + (xx / 32)];
        if (card == 0) return KEY;
        row = yy % 64;
        col = xx % 32;
        idx = (card + row / 8 + col / 4) % 8;
        if (idx == 0) return KEY;
        return pal_m[idx];
    endfunction

    task automatic host_write(input int xt, input int yt, input int card);
        int n;
        wr_xt    = 5'(xt);
        wr_yt    = 3'(yt);
        wr_card  = 4'(card);
        wr_valid = 1'b1;
        n = 0;
        while (!wr_ready && n < 50) begin
            tick();
            n++;
        end
        check("wr_ready_wait", {31'b0, wr_ready}, 1);
        tick();
        wr_valid = 1'b0;
        map_m[yt * 32 + xt] = card;
    endtask

    task automatic pal_write(input int idx, input int rgb);
        pal_idx = 3'(idx);
        pal_rgb = 12'(rgb);
        pal_we  = 1'b1;
        tick();
        pal_we  = 1'b0;
        if (idx != 0) pal_m[idx] = rgb;
    endtask

    task automatic look(input string tag, input int xx, input int yy);
        x = 11'(xx);
        y = 11'(yy);
        repeat (3) tick();
        check(tag, {20'b0, osd_rgb}, expect_pix(xx, yy));
    endtask

    task automatic do_clear();
        int n;
        wr_xt     = 5'd5;
        wr_yt     = 3'd5;
        wr_card   = 4'd7;
        wr_valid  = 1'b1;
        clr_start = 1'b1;
        #1;
        check("ready_on_clr_start", {31'b0, wr_ready}, 0);
        tick();
        clr_start = 1'b0;
        wr_valid  = 1'b0;
        check("ready_in_clear", {31'b0, wr_ready}, 0);
        n = 0;
        while (clr_busy && n < 1000) begin
            n++;
            tick();
        end
        check("clr_len", n, 256);
        for (int i = 0; i < 256; i++) map_m[i] = 0;
    endtask

    initial begin
        int q[$];
        int xx, yy, e;
        pal_m = def_pal;

        // 1: reset
        #2 reset_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            x = 11'($urandom_range(0, 1023));
            y = 11'($urandom_range(0, 511));
            tick();
        end
        check("rst_osd", {20'b0, osd_rgb}, KEY);
        check("rst_busy", {31'b0, clr_busy}, 0);
        check("rst_ready", {31'b0, wr_ready}, 0);
        reset_n = 1'b1;
        tick();
        check("ready_after_rst", {31'b0, wr_ready}, 1);

        // 2: single tile lookup
        host_write(2, 1, 3);
        look("tile_70_100", 70, 100);
        look("tile_68_64", 68, 64);

        // 3: clear
        do_clear();
        look("cleared_70_100", 70, 100);
        look("cleared_68_64", 68, 64);
        look("cleared_160_320", 160, 320);

        // 4: palette
        host_write(2, 1, 3);
        look("pal2_before", 92, 64);
        pal_write(2, 'h0f0);
        look("pal2_after", 92, 64);
        pal_write(0, 'h0ab);
        look("pal0_transparent", 84, 64);
        look("pal2_kept", 92, 64);

        // 5: bounds
        host_write(0, 0, 5);
        host_write(31, 7, 4);
        look("origin", 0, 0);
        look("x_1024", 1024, 0);
        look("y_512", 0, 512);
        look("last_pixel", 1023, 511);

        // random map/palette, then a streamed random scan
        for (int i = 0; i < 40; i++)
            host_write($urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 15));
        for (int i = 0; i < 6; i++)
            pal_write($urandom_range(0, 7), $urandom_range(0, 4095));
        for (int i = 0; i < 202; i++) begin
            if (i < 200) begin
                xx = $urandom_range(0, 1100);
                yy = $urandom_range(0, 560);
                x = 11'(xx);
                y = 11'(yy);
                q.push_back(expect_pix(xx, yy));
            end
            tick();
            if (i >= 2) begin
                e = q.pop_front();
                check("stream", {20'b0, osd_rgb}, e);
            end
        end

        // 6: reset in the middle of a clear
        host_write(0, 0, 5);
        host_write(10, 5, 6);
        pal_write(6, 'h123);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (100) tick();
        reset_n = 1'b0;
        #1;
        check("midclr_busy", {31'b0, clr_busy}, 0);
        check("midclr_ready", {31'b0, wr_ready}, 0);
        check("midclr_osd", {20'b0, osd_rgb}, KEY);
        for (int i = 0; i < 100; i++) map_m[i] = 0;
        pal_m = def_pal;
        tick();
        reset_n = 1'b1;
        tick();
        check("ready_after_midclr", {31'b0, wr_ready}, 1);
        look("partial_cleared_0", 0, 0);
        look("kept_170", 320, 320);
        look("kept_170_pal_reset", 336, 320);
        do_clear();
        look("recleared_170", 320, 320);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
